// File: rtl/clk_en_pkg.sv
// Shared constants for the clock-enable generator and its channel slices.
package clk_en_pkg;

    // Default divisor/counter width in bits.
    localparam int unsigned DIV_W_DEFAULT = 16;

    // Default divisor loaded into every channel at reset (0 = enable every cycle).
    localparam int unsigned DEFAULT_DIV_DEFAULT = 0;

    // Largest supported number of independent channels.
    localparam int unsigned MAX_CH = 16;

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: divide-by-(act+1) counter with a shadowed divisor that is
// only applied when the counter wraps, so a period is never cut short or stretched.
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_restart,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             ce_out,
    output logic             sq_out,
    output logic             div_pending
);

    localparam logic [DIV_W-1:0] RstDiv = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic             sq_q, sq_d;

    // Next-state: restart beats terminal/count; a load always lands in the shadow last,
    // so a load coinciding with a wrap queues behind the divisor being applied now.
    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        ce_d   = 1'b0;
        sq_d   = sq_q;

        if (sync_restart) begin
            cnt_d  = '0;
            sq_d   = 1'b0;
            pend_d = 1'b0;
            if (pend_q) begin
                act_d = shd_q;
            end
        end else if (en) begin
            if (cnt_q == act_q) begin
                cnt_d = '0;
                ce_d  = 1'b1;
                sq_d  = ~sq_q;
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        if (div_load) begin
            shd_d  = div_in;
            pend_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q  <= '0;
            act_q  <= RstDiv;
            shd_q  <= RstDiv;
            pend_q <= 1'b0;
            ce_q   <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            ce_q   <= ce_d;
            sq_q   <= sq_d;
        end
    end

    assign ce_out      = ce_q;
    assign sq_out      = sq_q;
    assign div_pending = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: NUM_CH independent dividers that share only
// the clock, reset and a common phase-alignment restart.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync_restart,
    input  logic [NUM_CH*DIV_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       sq_out,
    output logic [NUM_CH-1:0]       div_pending
);

    // One channel slice per enable; each takes its own DIV_W-wide divisor field.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clk_en_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_sys      (clk_sys),
            .reset        (reset),
            .en           (en[g]),
            .sync_restart (sync_restart),
            .div_in       (div_in[g*DIV_W +: DIV_W]),
            .div_load     (div_load[g]),
            .ce_out       (ce_out[g]),
            .sq_out       (sq_out[g]),
            .div_pending  (div_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen (3 channels, 16-bit divisors, reset divisor 0).
module tb_clk_en_gen;

    localparam int unsigned NCH = 3;
    localparam int unsigned DW  = 16;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [NCH-1:0]    en;
    logic              sync_restart;
    logic [NCH*DW-1:0] div_in;
    logic [NCH-1:0]    div_load;
    logic [NCH-1:0]    ce_out;
    logic [NCH-1:0]    sq_out;
    logic [NCH-1:0]    div_pending;

    int n_cmp = 0;
    int n_err = 0;

    clk_en_gen #(
        .NUM_CH      (NCH),
        .DIV_W       (DW),
        .DEFAULT_DIV (0)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .en           (en),
        .sync_restart (sync_restart),
        .div_in       (div_in),
        .div_load     (div_load),
        .ce_out       (ce_out),
        .sq_out       (sq_out),
        .div_pending  (div_pending)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        en           = '0;
        sync_restart = 1'b0;
        div_in       = '0;
        div_load     = '0;
        step();
        step();
        chk("rst_ce", 32'(ce_out), 32'h0);
        chk("rst_sq", 32'(sq_out), 32'h0);
        chk("rst_pend", 32'(div_pending), 32'h0);

        // Divisor 0 after reset: enable every cycle, square wave toggles every cycle.
        reset = 1'b0;
        en    = 3'b111;
        step();
        chk("d0_ce_e1", 32'(ce_out), 32'h7);
        chk("d0_sq_e1", 32'(sq_out), 32'h7);
        step();
        chk("d0_ce_e2", 32'(ce_out), 32'h7);
        chk("d0_sq_e2", 32'(sq_out), 32'h0);
        step();
        chk("d0_sq_e3", 32'(sq_out), 32'h7);

        // Channel 1 divisor 4, then restart: pulses on edges 5, 10, 15.
        div_in[DW +: DW] = 16'd4;
        div_load         = 3'b010;
        step();
        div_load = '0;
        chk("b_pend", 32'(div_pending), 32'h2);
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        chk("b_rs_ce", 32'(ce_out), 32'h0);
        chk("b_rs_sq", 32'(sq_out), 32'h0);
        chk("b_rs_pend", 32'(div_pending), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            logic [2:0] ece;
            logic [2:0] esq;
            step();
            ece = {1'b1, (k % 5) == 0, 1'b1};
            esq = {(k % 2) == 1, ((k / 5) % 2) == 1, (k % 2) == 1};
            chk($sformatf("b_ce_e%0d", k), 32'(ce_out), 32'(ece));
            chk($sformatf("b_sq_e%0d", k), 32'(sq_out), 32'(esq));
        end

        // Channel 0 act=9, load 2 while cnt=3: terminal at edge 10, then every 3.
        div_in[0 +: DW] = 16'd9;
        div_load        = 3'b001;
        step();
        div_load     = '0;
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        step();
        step();
        step();
        div_in[0 +: DW] = 16'd2;
        div_load        = 3'b001;
        step();
        div_load = '0;
        chk("c_pend_e4", 32'(div_pending[0]), 32'h1);
        chk("c_ce_e4", 32'(ce_out[0]), 32'h0);
        for (int k = 5; k <= 16; k++) begin
            step();
            chk($sformatf("c_ce_e%0d", k), 32'(ce_out[0]),
                32'((k == 10) || (k == 13) || (k == 16)));
            chk($sformatf("c_pend_e%0d", k), 32'(div_pending[0]), 32'(k < 10));
        end

        // Channel 0 act=3, pending 5, load 7 on the terminal: periods 6 then 8.
        div_in[0 +: DW] = 16'd3;
        div_load        = 3'b001;
        step();
        div_load     = '0;
        sync_restart = 1'b1;
        step();
        sync_restart    = 1'b0;
        div_in[0 +: DW] = 16'd5;
        div_load        = 3'b001;
        step();
        div_load = '0;
        chk("d_pend_e1", 32'(div_pending[0]), 32'h1);
        step();
        step();
        div_in[0 +: DW] = 16'd7;
        div_load        = 3'b001;
        step();
        div_load = '0;
        chk("d_ce_e4", 32'(ce_out[0]), 32'h1);
        chk("d_pend_e4", 32'(div_pending[0]), 32'h1);
        for (int k = 5; k <= 18; k++) begin
            step();
            chk($sformatf("d_ce_e%0d", k), 32'(ce_out[0]), 32'((k == 10) || (k == 18)));
            chk($sformatf("d_pend_e%0d", k), 32'(div_pending[0]), 32'(k < 10));
        end

        // Channel 2 act=5 with en low on edges 3..6: pulse slips from edge 6 to 10.
        div_in[2*DW +: DW] = 16'd5;
        div_load           = 3'b100;
        step();
        div_load     = '0;
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            en[2] = !((k >= 3) && (k <= 6));
            step();
            chk($sformatf("e_ce_e%0d", k), 32'(ce_out[2]), 32'(k == 10));
            chk($sformatf("e_sq_e%0d", k), 32'(sq_out[2]), 32'(k >= 10));
        end
        en = 3'b111;

        // Pending load on channel 2 at cnt=2, then reset discards everything.
        div_in[2*DW +: DW] = 16'd9;
        div_load           = 3'b100;
        step();
        div_load = '0;
        chk("f_pend", 32'(div_pending[2]), 32'h1);
        reset = 1'b1;
        step();
        chk("f_rst_ce", 32'(ce_out), 32'h0);
        chk("f_rst_sq", 32'(sq_out), 32'h0);
        chk("f_rst_pend", 32'(div_pending), 32'h0);
        reset = 1'b0;
        step();
        chk("f_post_ce", 32'(ce_out), 32'h7);
        chk("f_post_sq", 32'(sq_out), 32'h7);
        chk("f_post_pend", 32'(div_pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
